// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8 -- eight-way round-robin arbiter with hold timeout.
//
// A requester is granted for as long as it keeps its request up and has not
// signalled done, up to TIMEOUT cycles. Every grant is followed by exactly
// one GAP cycle with no grant. Arbitration resumes in that GAP cycle, so a
// done at cycle M produces the next grant at cycle M+2. The search for the
// next holder starts one past the most recent holder (last_sel), which gives
// round-robin fairness.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous active-high reset
//   req          in   8  request per requester, bit i = requester i
//   done         in   1  current holder finished (only looked at in GRANT)
//   gnt          out  8  registered one-hot grant, zero when nobody holds
//   gnt_sel      out  3  binary index of the holder (meaningful when gnt_valid)
//   gnt_valid    out  1  high exactly when gnt is non-zero
//   timeout_err  out  1  one-cycle pulse in the GAP after a forced release
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int TIMEOUT = 16          // legal range 2..256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_sel,
    output logic       gnt_valid,
    output logic       timeout_err
);

    // The counter never goes past TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_last_sel;
    logic [2:0]    w_last_sel_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [7:0]    r_gnt;
    logic [7:0]    w_gnt_next;
    logic [2:0]    r_gnt_sel;
    logic [2:0]    w_gnt_sel_next;
    logic          r_gnt_valid;
    logic          w_gnt_valid_next;
    logic          r_timeout_err;
    logic          w_timeout_err_next;

    // Requests rotated so that bit k is requester (last_sel + 1 + k) mod 8.
    // Offset 7 wraps back onto last_sel itself, so a lone requester is
    // re-granted after its GAP.
    logic [7:0] w_rot;
    logic [2:0] w_off;
    logic [2:0] w_pick;
    logic [7:0] w_pick_onehot;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rotate
            assign w_rot[gi]         = req[r_last_sel + 3'(gi + 1)];
            assign w_pick_onehot[gi] = (w_pick == 3'(gi));
        end
    endgenerate

    // Lowest set rotated bit wins; scanning downward lets it overwrite.
    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_pick = r_last_sel + w_off + 3'd1;

    logic w_hold_req;
    logic w_timed_out;
    assign w_hold_req  = req[r_gnt_sel];
    assign w_timed_out = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next       = r_state;
        w_last_sel_next    = r_last_sel;
        w_cnt_next         = r_cnt;
        w_gnt_next         = r_gnt;
        w_gnt_sel_next     = r_gnt_sel;
        w_gnt_valid_next   = r_gnt_valid;
        w_timeout_err_next = 1'b0;

        case (r_state)
            IDLE, GAP: begin
                if (|req) begin
                    w_state_next     = GRANT;
                    w_gnt_next       = w_pick_onehot;
                    w_gnt_sel_next   = w_pick;
                    w_gnt_valid_next = 1'b1;
                    w_last_sel_next  = w_pick;
                end else begin
                    w_state_next     = IDLE;
                    w_gnt_next       = 8'd0;
                    w_gnt_valid_next = 1'b0;
                end
                w_cnt_next = '0;
            end
            GRANT: begin
                if (done || !w_hold_req || w_timed_out) begin
                    w_state_next       = GAP;
                    w_gnt_next         = 8'd0;
                    w_gnt_valid_next   = 1'b0;
                    // A done or abandon in the same cycle counts as a
                    // normal release, so only a pure timeout is flagged.
                    w_timeout_err_next = w_timed_out && !done && w_hold_req;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_gnt_next       = 8'd0;
                w_gnt_valid_next = 1'b0;
                w_cnt_next       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_sel    <= 3'd7;
            r_cnt         <= '0;
            r_gnt         <= 8'd0;
            r_gnt_sel     <= 3'd0;
            r_gnt_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_sel    <= w_last_sel_next;
            r_cnt         <= w_cnt_next;
            r_gnt         <= w_gnt_next;
            r_gnt_sel     <= w_gnt_sel_next;
            r_gnt_valid   <= w_gnt_valid_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_sel     = r_gnt_sel;
    assign gnt_valid   = r_gnt_valid;
    assign timeout_err = r_timeout_err;

endmodule
